// File: rtl/if_id_skid_reg_pkg.sv
// Shared pipeline definitions for the IF/ID stage register: state encoding and
// the default bubble instruction.
package if_id_skid_reg_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } ifid_state_e;

   // RISC-V canonical NOP: addi x0, x0, 0
   localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

   localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with optional 2-entry skid buffer so that fetch sees
// a registered ready; also counts decode-side stall cycles (saturating).
module if_id_skid_reg
   import if_id_skid_reg_pkg::*;
#(
   parameter int                XLEN     = 32,
   parameter int                ILEN     = 32,
   parameter logic [ILEN-1:0]   NOP_INST = ILEN'(NOP_INST_DEFAULT),
   parameter int                SKID_EN  = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [XLEN-1:0]        in_pc_i,
   input  logic [ILEN-1:0]        in_inst_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [XLEN-1:0]        out_pc_o,
   output logic [ILEN-1:0]        out_inst_o,
   output logic [STALL_CNT_W-1:0] stall_cnt_o
);

   localparam int PLEN = XLEN + ILEN;
   localparam logic [PLEN-1:0] NOP_PAYLOAD = {{XLEN{1'b0}}, NOP_INST};

   ifid_state_e             state_q, state_d;
   logic [PLEN-1:0]         main_q, main_d;
   logic [PLEN-1:0]         skid_q, skid_d;
   logic [STALL_CNT_W-1:0]  stall_cnt_q;
   logic [PLEN-1:0]         in_payload;
   logic                    in_fire;
   logic                    out_fire;

   assign in_payload  = {in_pc_i, in_inst_i};
   assign out_valid_o = (state_q != ST_EMPTY);
   assign in_fire     = in_valid_i && in_ready_o;
   assign out_fire    = out_valid_o && out_ready_i;

   assign out_pc_o    = main_q[PLEN-1:ILEN];
   assign out_inst_o  = main_q[ILEN-1:0];
   assign stall_cnt_o = stall_cnt_q;

   // NOTE: every signal written here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush_i) begin
         state_d = ST_EMPTY;
         main_d  = NOP_PAYLOAD;
         skid_d  = NOP_PAYLOAD;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d = ST_FULL;
                  main_d  = in_payload;
               end
            end
            ST_FULL: begin
               if (in_fire && out_fire) begin
                  main_d = in_payload;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
                  main_d  = NOP_PAYLOAD;
               end else if (in_fire) begin
                  // Only reachable with the skid buffer; without it ready is low here.
                  state_d = ST_SKID;
                  skid_d  = in_payload;
               end
            end
            ST_SKID: begin
               if (out_fire) begin
                  state_d = ST_FULL;
                  main_d  = skid_q;
                  skid_d  = NOP_PAYLOAD;
               end
            end
            default: begin
               state_d = ST_EMPTY;
               main_d  = NOP_PAYLOAD;
               skid_d  = NOP_PAYLOAD;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         // NOTE: payload registers are reset too, so decode sees 0/NOP, never X.
         main_q  <= NOP_PAYLOAD;
         skid_q  <= NOP_PAYLOAD;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (out_valid_o && !out_ready_i && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   generate
      if (SKID_EN != 0) begin : g_skid
         // Ready comes straight from a flop: fetch timing is isolated from decode.
         logic in_ready_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               in_ready_q <= 1'b1;
            end else begin
               in_ready_q <= (state_d != ST_SKID);
            end
         end
         assign in_ready_o = in_ready_q;
      end else begin : g_single
         assign in_ready_o = !out_valid_o || out_ready_i;
      end
   endgenerate

endmodule

// File: doc/if_id_skid_reg.md
IF_ID_SKID_REG -- requirements
Module: if_id_skid_reg

Interface
REQ-001 SHALL have parameter XLEN, default 32, the PC width in bits.
REQ-002 SHALL have parameter ILEN, default 32, the instruction width in bits.
REQ-003 SHALL have parameter NOP_INST, default 32'h0000_0013, the instruction presented after reset or flush.
REQ-004 SHALL have parameter SKID_EN, default 1: 1 selects a 2-entry skid buffer, 0 selects a single-entry register.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port flush_i, input, 1 bit: kills all held and incoming entries.
REQ-008 SHALL have port in_valid_i, input, 1 bit: the fetch stage offers in_pc_i/in_inst_i.
REQ-009 SHALL have port in_ready_o, output, 1 bit: the block accepts the current offer.
REQ-010 SHALL have port in_pc_i, input, XLEN bits: fetch PC.
REQ-011 SHALL have port in_inst_i, input, ILEN bits: fetched instruction.
REQ-012 SHALL have port out_valid_o, output, 1 bit: decode payload is valid.
REQ-013 SHALL have port out_ready_i, input, 1 bit: decode consumes the payload; low means hazard stall.
REQ-014 SHALL have port out_pc_o, output, XLEN bits: PC to decode.
REQ-015 SHALL have port out_inst_o, output, ILEN bits: instruction to decode.
REQ-016 SHALL have port stall_cnt_o, output, 16 bits: saturating count of stalled cycles.

Function
REQ-017 A transfer SHALL occur on any edge where valid and ready are both high on the same side; no other edge transfers.
REQ-018 With SKID_EN=1, the block SHALL implement states EMPTY, FULL (main entry held) and SKID (main and skid entries held).
REQ-019 EMPTY SHALL go to FULL on an input transfer.
REQ-020 FULL SHALL stay FULL on an input transfer plus an output transfer, with the main entry taking the new data.
REQ-021 FULL SHALL go to EMPTY on an output transfer only.
REQ-022 FULL SHALL go to SKID on an input transfer only, with the new data written to the skid entry.
REQ-023 SKID SHALL go to FULL on an output transfer, with the skid entry moving to the main entry.
REQ-024 With SKID_EN=1, in_ready_o SHALL be registered and high exactly when the state is not SKID; it SHALL have no combinational path from out_ready_i.
REQ-025 With SKID_EN=0, in_ready_o SHALL equal !out_valid_o || out_ready_i, and depth SHALL be 1.
REQ-026 Latency SHALL be 1 cycle from input transfer to out_valid_o when the block was EMPTY.
REQ-027 Order SHALL be strictly FIFO; no entry may be lost or duplicated.
REQ-028 out_valid_o SHALL be high exactly in FULL or SKID.
REQ-029 out_pc_o/out_inst_o SHALL always show the main entry; when EMPTY they SHALL show 0/NOP_INST, never X.
REQ-030 Outputs SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-031 flush_i SHALL have priority over all other events: on the next edge state becomes EMPTY, both entries clear to 0/NOP_INST, and any same-cycle input or output transfer is discarded.
REQ-032 in_ready_o SHALL be high in the cycle after a flush.
REQ-033 stall_cnt_o SHALL increment on each edge where out_valid_o=1 and out_ready_i=0.
REQ-034 stall_cnt_o SHALL saturate at 16'hFFFF.
REQ-035 stall_cnt_o SHALL be unaffected by flush_i.

Reset
REQ-036 When rst_n=0, the block SHALL go to EMPTY immediately, independent of clk.
REQ-037 Reset values SHALL be: out_valid_o=0, in_ready_o=1 (SKID_EN=1), out_pc_o=0, out_inst_o=NOP_INST, skid entry 0/NOP_INST, stall_cnt_o=0.
REQ-038 An assertion of rst_n mid-operation SHALL discard all held entries without emitting any transfer.
REQ-039 The first transfer after rst_n deassertion SHALL be accepted on the first rising edge with rst_n=1.

Structure
REQ-040 The state encoding (EMPTY/FULL/SKID) and the NOP_INST default constant SHALL reside in the shared pipeline package.
REQ-041 The block SHALL be flat, with no sub-module; the payload SHALL be handled as one {pc,inst} vector of XLEN+ILEN bits.

Verification
REQ-042 Reset: with rst_n low mid-SKID, out_valid_o=0, in_ready_o=1, out_inst_o=32'h13 and stall_cnt_o=0 immediately.
REQ-043 Streaming: with out_ready_i=1, input PC 0x0,0x4,0x8 arrives on consecutive edges; outputs appear 1 cycle later in order, with in_ready_o held high.
REQ-044 Stall/skid: holding out_ready_i=0 while sending PCs 0x10 and 0x14 yields SKID with in_ready_o=0; releasing out_ready_i yields 0x10 then 0x14, and stall_cnt_o equals the number of stalled cycles.
REQ-045 Flush: flush_i in SKID with in_valid_i=1 (PC 0x20) yields EMPTY next cycle, out_inst_o=NOP_INST, and 0x20 never emitted.
REQ-046 Saturation: 70000 stalled cycles yield stall_cnt_o=16'hFFFF that stays there.
REQ-047 SKID_EN=0: the same stream with random out_ready_i yields identical ordering, with in_ready_o following out_ready_i combinationally.
